// File: rtl/eclusa_escalonador.sv
// Transit scheduler for a two-gate canal lock: arbitrates boat requests, sequences the
// fill/drain valves and issues gate open-requests while never letting both gates open.
module eclusa_escalonador #(
  parameter int T_NIVEL    = 50,
  parameter int T_PASSAGEM = 100,
  parameter int TW         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pedidoMontante,
  input  logic       pedidoJusante,
  input  logic       fechadaM,
  input  logic       abertaM,
  input  logic       fechadaJ,
  input  logic       abertaJ,
  input  logic       emergencia,
  output logic       abrirM,
  output logic       abrirJ,
  output logic       valvulaEnchimento,
  output logic       valvulaEsvaziamento,
  output logic [1:0] atendendo,
  output logic       ocupado,
  output logic [3:0] dbEstado
);

  typedef enum logic [3:0] {
    OCIOSO           = 4'd0,
    ARBITRA          = 4'd1,
    NIVELA_ENTRADA   = 4'd2,
    ABRE_ENTRADA     = 4'd3,
    PASSAGEM_ENTRADA = 4'd4,
    FECHA_ENTRADA    = 4'd5,
    NIVELA_SAIDA     = 4'd6,
    ABRE_SAIDA       = 4'd7,
    PASSAGEM_SAIDA   = 4'd8,
    FECHA_SAIDA      = 4'd9,
    EMERGENCIA       = 4'd10
  } estado_t;

  localparam logic [TW-1:0] FIM_NIVEL    = TW'(T_NIVEL - 1);
  localparam logic [TW-1:0] FIM_PASSAGEM = TW'(T_PASSAGEM - 1);

  estado_t       estado_q, estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_m_q, pend_m_d;
  logic          pend_j_q, pend_j_d;
  logic          nivel_alto_q, nivel_alto_d;
  logic          ultimo_m_q, ultimo_m_d;
  logic          entrada_m_q, entrada_m_d;

  logic fechada_e, aberta_e, fechada_s, aberta_s;
  logic grant_m;
  logic abrir_e, abrir_s;

  // Gate flags seen from the current transit: E is the entry side, S the exit side.
  always_comb begin
    fechada_e = entrada_m_q ? fechadaM : fechadaJ;
    aberta_e  = entrada_m_q ? abertaM  : abertaJ;
    fechada_s = entrada_m_q ? fechadaJ : fechadaM;
    aberta_s  = entrada_m_q ? abertaJ  : abertaM;
    grant_m   = pend_m_q & (~pend_j_q | ~ultimo_m_q);
  end

  always_comb begin
    estado_d     = estado_q;
    pend_m_d     = pend_m_q | pedidoMontante;
    pend_j_d     = pend_j_q | pedidoJusante;
    nivel_alto_d = nivel_alto_q;
    ultimo_m_d   = ultimo_m_q;
    entrada_m_d  = entrada_m_q;

    if (emergencia) begin
      estado_d = EMERGENCIA;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (pend_m_q || pend_j_q) estado_d = ARBITRA;
        end
        ARBITRA: begin
          if (!pend_m_q && !pend_j_q) begin
            estado_d = OCIOSO;
          end else begin
            entrada_m_d = grant_m;
            ultimo_m_d  = grant_m;
            // A pulse arriving in the grant cycle is absorbed by this grant.
            if (grant_m) pend_m_d = 1'b0;
            else         pend_j_d = 1'b0;
            estado_d = (grant_m == nivel_alto_q) ? ABRE_ENTRADA : NIVELA_ENTRADA;
          end
        end
        NIVELA_ENTRADA: begin
          if (timer_q == FIM_NIVEL) begin
            nivel_alto_d = entrada_m_q;
            estado_d     = ABRE_ENTRADA;
          end
        end
        ABRE_ENTRADA: begin
          if (aberta_e) estado_d = PASSAGEM_ENTRADA;
        end
        PASSAGEM_ENTRADA: begin
          if (timer_q == FIM_PASSAGEM) estado_d = FECHA_ENTRADA;
        end
        FECHA_ENTRADA: begin
          if (fechada_e)
            estado_d = (~entrada_m_q == nivel_alto_q) ? ABRE_SAIDA : NIVELA_SAIDA;
        end
        NIVELA_SAIDA: begin
          if (timer_q == FIM_NIVEL) begin
            nivel_alto_d = ~entrada_m_q;
            estado_d     = ABRE_SAIDA;
          end
        end
        ABRE_SAIDA: begin
          if (aberta_s) estado_d = PASSAGEM_SAIDA;
        end
        PASSAGEM_SAIDA: begin
          if (timer_q == FIM_PASSAGEM) estado_d = FECHA_SAIDA;
        end
        FECHA_SAIDA: begin
          if (fechada_s) estado_d = OCIOSO;
        end
        EMERGENCIA: begin
          if (fechadaM && fechadaJ) estado_d = OCIOSO;
        end
        default: estado_d = OCIOSO;
      endcase
    end
  end

  // The timer restarts on every state change, so an interrupted equalization reruns in full.
  always_comb begin
    timer_d = timer_q;
    if (estado_d != estado_q) begin
      timer_d = '0;
    end else begin
      case (estado_q)
        NIVELA_ENTRADA, PASSAGEM_ENTRADA, NIVELA_SAIDA, PASSAGEM_SAIDA:
          timer_d = timer_q + 1'b1;
        default: timer_d = timer_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      timer_q      <= '0;
      pend_m_q     <= 1'b0;
      pend_j_q     <= 1'b0;
      nivel_alto_q <= 1'b0;
      ultimo_m_q   <= 1'b0;
      entrada_m_q  <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      timer_q      <= timer_d;
      pend_m_q     <= pend_m_d;
      pend_j_q     <= pend_j_d;
      nivel_alto_q <= nivel_alto_d;
      ultimo_m_q   <= ultimo_m_d;
      entrada_m_q  <= entrada_m_d;
    end
  end

  // An open request is only issued while the opposite gate reports closed.
  always_comb begin
    abrir_e             = 1'b0;
    abrir_s             = 1'b0;
    valvulaEnchimento   = 1'b0;
    valvulaEsvaziamento = 1'b0;
    case (estado_q)
      NIVELA_ENTRADA: begin
        valvulaEnchimento   = entrada_m_q;
        valvulaEsvaziamento = ~entrada_m_q;
      end
      ABRE_ENTRADA:     abrir_e = fechada_s;
      PASSAGEM_ENTRADA: abrir_e = 1'b1;
      NIVELA_SAIDA: begin
        valvulaEnchimento   = ~entrada_m_q;
        valvulaEsvaziamento = entrada_m_q;
      end
      ABRE_SAIDA:       abrir_s = fechada_e;
      PASSAGEM_SAIDA:   abrir_s = 1'b1;
      default: begin
        abrir_e = 1'b0;
        abrir_s = 1'b0;
      end
    endcase
    abrirM = entrada_m_q ? abrir_e : abrir_s;
    abrirJ = entrada_m_q ? abrir_s : abrir_e;
  end

  always_comb begin
    atendendo = 2'b00;
    dbEstado  = 4'hF;
    ocupado   = (estado_q != OCIOSO);
    case (estado_q)
      NIVELA_ENTRADA, ABRE_ENTRADA, PASSAGEM_ENTRADA, FECHA_ENTRADA,
      NIVELA_SAIDA, ABRE_SAIDA, PASSAGEM_SAIDA, FECHA_SAIDA: begin
        atendendo = entrada_m_q ? 2'b01 : 2'b10;
        dbEstado  = estado_q;
      end
      OCIOSO, ARBITRA, EMERGENCIA: dbEstado = estado_q;
      default: dbEstado = 4'hF;
    endcase
  end

  interlock_a: assert property (@(posedge clock) disable iff (reset) !(abrirM && abrirJ));
  valvulas_a:  assert property (@(posedge clock) disable iff (reset)
                                !(valvulaEnchimento && valvulaEsvaziamento));

endmodule

// File: tb/tb_eclusa_escalonador.sv
// Bench for eclusa_escalonador: gate-unit model plus a scoreboard of expected state runs,
// each with its length and entry side, checked cycle by cycle against the outputs.
module tb_eclusa_escalonador;

  localparam int TN = 4;
  localparam int TP = 3;

  typedef struct {
    logic [3:0] code;
    int         len;
    logic [1:0] atend;
  } item_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pedidoMontante = 1'b0, pedidoJusante = 1'b0, emergencia = 1'b0;
  logic       fechadaM, abertaM, fechadaJ, abertaJ;
  logic       abrirM, abrirJ, valvulaEnchimento, valvulaEsvaziamento, ocupado;
  logic [1:0] atendendo;
  logic [3:0] dbEstado;

  int    vectors = 0, miscompares = 0;
  int    pos_m = 0, pos_j = 0;
  bit    hold_m = 0, hold_j = 0;
  bit    model_nivel = 0;
  item_t exp_q[$];
  item_t cur;
  bit    mon_en = 0, mon_active = 0;
  logic [3:0] mon_prev = 4'h0;
  int    run_len = 0;

  eclusa_escalonador #(.T_NIVEL(TN), .T_PASSAGEM(TP), .TW(8)) dut (
    .clock(clock), .reset(reset),
    .pedidoMontante(pedidoMontante), .pedidoJusante(pedidoJusante),
    .fechadaM(fechadaM), .abertaM(abertaM), .fechadaJ(fechadaJ), .abertaJ(abertaJ),
    .emergencia(emergencia),
    .abrirM(abrirM), .abrirJ(abrirJ),
    .valvulaEnchimento(valvulaEnchimento), .valvulaEsvaziamento(valvulaEsvaziamento),
    .atendendo(atendendo), .ocupado(ocupado), .dbEstado(dbEstado)
  );

  always #5 clock = ~clock;

  // Gate units take two cycles of travel each way; hold_x pins a gate's closed flag low.
  assign fechadaM = (pos_m == 0) && !hold_m;
  assign abertaM  = (pos_m == 2);
  assign fechadaJ = (pos_j == 0) && !hold_j;
  assign abertaJ  = (pos_j == 2);

  always @(posedge clock) begin
    #1;
    if (abrirM && pos_m < 2) pos_m++;
    else if (!abrirM && pos_m > 0) pos_m--;
    if (abrirJ && pos_j < 2) pos_j++;
    else if (!abrirJ && pos_j > 0) pos_j--;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic pushItem(input logic [3:0] code, input int len, input logic [1:0] atend);
    item_t it;
    it.code = code; it.len = len; it.atend = atend;
    exp_q.push_back(it);
  endtask

  // Expected run sequence of one transit, derived from the chamber level the bench tracks.
  task automatic pushTransit(input bit ent_m, input int trail, input int abre_s_len);
    logic [1:0] a;
    a = ent_m ? 2'b01 : 2'b10;
    pushItem(4'd1, 1, 2'b00);
    if (model_nivel != ent_m) begin
      pushItem(4'd2, TN, a);
      model_nivel = ent_m;
    end
    pushItem(4'd3, 2, a);
    pushItem(4'd4, TP, a);
    pushItem(4'd5, 2, a);
    if (model_nivel != !ent_m) begin
      pushItem(4'd6, TN, a);
      model_nivel = !ent_m;
    end
    pushItem(4'd7, abre_s_len, a);
    pushItem(4'd8, TP, a);
    pushItem(4'd9, 2, a);
    pushItem(4'd0, trail, 2'b00);
  endtask

  task automatic applyStimulus(input bit m, input bit j);
    pedidoMontante = m;
    pedidoJusante  = j;
    @(negedge clock); #1;
    pedidoMontante = 1'b0;
    pedidoJusante  = 1'b0;
  endtask

  task automatic applyReset();
    mon_en = 0;
    reset = 1'b1;
    pedidoMontante = 0; pedidoJusante = 0; emergencia = 0;
    hold_m = 0; hold_j = 0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    model_nivel = 0;
    mon_active = 0;
  endtask

  task automatic waitState(input logic [3:0] code, input int budget, input string tag);
    int n = 0;
    while (dbEstado !== code && n < budget) begin
      @(negedge clock); #1;
      n++;
    end
    checkOutput(tag, 32'(dbEstado), 32'(code));
  endtask

  task automatic waitDone(input string tag);
    waitState(4'd9, 300, {tag, "_reach9"});
    waitState(4'd0, 20, {tag, "_reach0"});
  endtask

  // Scoreboard monitor: pops one expected run per state change and checks every output each cycle.
  always @(posedge clock) begin
    logic [3:0] s;
    bit e_m, e_j, x_fill, x_drain, x_am, x_aj;
    #3;
    if (mon_en && !reset) begin
      s = dbEstado;
      if (!mon_active || s != mon_prev) begin
        if (mon_active && cur.len != 0)
          checkOutput($sformatf("run_len_%0h", mon_prev), 32'(run_len), 32'(cur.len));
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_state", 32'(s), 32'(mon_prev));
          cur.len = 0;
        end else begin
          cur = exp_q.pop_front();
          checkOutput("state", 32'(s), 32'(cur.code));
        end
        mon_prev = s;
        mon_active = 1;
        run_len = 0;
      end
      run_len++;
      e_m = (cur.atend == 2'b01);
      e_j = (cur.atend == 2'b10);
      x_fill  = (cur.code == 4'd2 && e_m) || (cur.code == 4'd6 && e_j);
      x_drain = (cur.code == 4'd2 && e_j) || (cur.code == 4'd6 && e_m);
      x_am = (cur.code == 4'd3 && e_m && fechadaJ) || (cur.code == 4'd4 && e_m) ||
             (cur.code == 4'd7 && e_j && fechadaJ) || (cur.code == 4'd8 && e_j);
      x_aj = (cur.code == 4'd3 && e_j && fechadaM) || (cur.code == 4'd4 && e_j) ||
             (cur.code == 4'd7 && e_m && fechadaM) || (cur.code == 4'd8 && e_m);
      checkOutput("atendendo", 32'(atendendo), 32'(cur.atend));
      checkOutput("ocupado", 32'(ocupado), 32'(cur.code != 4'd0));
      checkOutput("fill", 32'(valvulaEnchimento), 32'(x_fill));
      checkOutput("drain", 32'(valvulaEsvaziamento), 32'(x_drain));
      checkOutput("abrirM", 32'(abrirM), 32'(x_am));
      checkOutput("abrirJ", 32'(abrirJ), 32'(x_aj));
      checkOutput("interlock", 32'(abrirM & abrirJ), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state, observed while reset is still asserted
    #1;
    checkOutput("rst_estado", 32'(dbEstado), 32'd0);
    checkOutput("rst_outs", 32'({abrirM, abrirJ, valvulaEnchimento, valvulaEsvaziamento,
                                 atendendo, ocupado}), 32'd0);

    // Single M transit: full walk 0..9,0 with both equalizations
    applyReset();
    pushItem(4'd0, 0, 2'b00);
    pushTransit(1'b1, 0, 2);
    mon_en = 1;
    applyStimulus(1'b1, 1'b0);
    waitDone("t1");

    // Interlock: M gate reports not-closed while J is being opened
    pushTransit(1'b1, 0, 0);
    applyStimulus(1'b1, 1'b0);
    waitState(4'd6, 100, "t3_reach6");
    hold_m = 1;
    waitState(4'd7, 20, "t3_reach7");
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_abrirJ_held", 32'(abrirJ), 32'd0);
      @(negedge clock); #1;
    end
    hold_m = 0;
    @(negedge clock); #1;
    checkOutput("t3_abrirJ_release", 32'(abrirJ), 32'd1);
    waitDone("t3");

    // Queueing: J request arrives during M passage
    pushTransit(1'b1, 1, 2);
    applyStimulus(1'b1, 1'b0);
    waitState(4'd4, 100, "t6_reach4");
    pushTransit(1'b0, 0, 2);
    applyStimulus(1'b0, 1'b1);
    waitDone("t6_m");
    waitState(4'd3, 10, "t6_reach3");
    checkOutput("t6_atend_j", 32'(atendendo), 32'd2);
    waitDone("t6_j");

    // Tie after reset: M first, then J with entry equalization skipped
    applyReset();
    pushItem(4'd0, 0, 2'b00);
    pushTransit(1'b1, 1, 2);
    pushTransit(1'b0, 0, 2);
    mon_en = 1;
    applyStimulus(1'b1, 1'b1);
    waitState(4'd3, 50, "t2_reach3a");
    checkOutput("t2_first_atend", 32'(atendendo), 32'd1);
    waitDone("t2_m");
    waitState(4'd1, 5, "t2_reach1");
    @(negedge clock); #1;
    checkOutput("t2_skip_nivela", 32'(dbEstado), 32'd3);
    checkOutput("t2_second_atend", 32'(atendendo), 32'd2);
    waitDone("t2_j");

    // Emergency during entry passage; level is already high so M enters directly
    pushTransit(1'b1, 0, 2);
    applyStimulus(1'b1, 1'b0);
    waitState(4'd4, 50, "t4_reach4");
    emergencia = 1;
    cur.len = 0;
    exp_q.delete();
    pushItem(4'hA, 0, 2'b00);
    @(negedge clock); #1;
    checkOutput("t4_estado_A", 32'(dbEstado), 32'hA);
    checkOutput("t4_outs_off", 32'({abrirM, abrirJ, valvulaEnchimento, valvulaEsvaziamento}), 32'd0);
    hold_j = 1;
    emergencia = 0;
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4_stay_A", 32'(dbEstado), 32'hA);
      @(negedge clock); #1;
    end
    model_nivel = 1;
    pushItem(4'd0, 1, 2'b00);
    pushTransit(1'b0, 0, 2);
    hold_j = 0;
    waitState(4'd0, 10, "t4_exit");
    waitState(4'd3, 20, "t4_reach3");
    checkOutput("t4_served_j", 32'(atendendo), 32'd2);
    waitDone("t4");

    // Async reset mid entry equalization, with a fresh M request pending
    pushItem(4'd1, 1, 2'b00);
    pushItem(4'd2, 0, 2'b10);
    applyStimulus(1'b0, 1'b1);
    waitState(4'd2, 10, "t5_reach2");
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_drain_on", 32'(valvulaEsvaziamento), 32'd1);
    mon_en = 0;
    #2 reset = 1'b1;
    #1;
    checkOutput("t5_async_estado", 32'(dbEstado), 32'd0);
    checkOutput("t5_async_outs", 32'({abrirM, abrirJ, valvulaEnchimento, valvulaEsvaziamento,
                                      atendendo, ocupado}), 32'd0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    model_nivel = 0;
    mon_active = 0;
    pushItem(4'd0, 0, 2'b00);
    mon_en = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); #1;
      checkOutput("t5_pend_cleared", 32'(dbEstado), 32'd0);
    end
    pushTransit(1'b0, 0, 2);
    applyStimulus(1'b0, 1'b1);
    waitState(4'd1, 5, "t5_reach1");
    @(negedge clock); #1;
    checkOutput("t5_nivel_reset", 32'(dbEstado), 32'd3);
    waitDone("t5");

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eclusa_escalonador.md
Name: eclusa_escalonador

Overview:
- Transit scheduler for a two-gate canal lock: upstream gate (montante, M) and downstream gate (jusante, J).
- Each gate is driven by its own gate control unit. This block issues each unit's open-request and reads back its closed/open position flags.
- It also sequences the chamber fill and drain valves, and arbitrates round-robin between boat requests from both sides.
- It never lets both gates open at once.

Parameters:
- T_NIVEL, 50: cycles a valve is held to equalize the chamber level.
- T_PASSAGEM, 100: cycles a gate is held open after reaching its open position.
- TW, 8: timer width. Requires T_NIVEL and T_PASSAGEM to be at most 2^TW.

Ports:
- clock  in  1  system clock
- reset  in  1  reset; asynchronous, active-high
- pedidoMontante  in  1  boat request pulse from upstream side
- pedidoJusante  in  1  boat request pulse from downstream side
- fechadaM  in  1  gate M at closed position (start-of-travel flag from gate unit)
- abertaM  in  1  gate M at open position (end-of-travel flag from gate unit)
- fechadaJ  in  1  gate J closed
- abertaJ  in  1  gate J open
- emergencia  in  1  force-close request, level-sensitive
- abrirM  out  1  open request to gate M unit
- abrirJ  out  1  open request to gate J unit
- valvulaEnchimento  out  1  fill valve (raises chamber to upstream level)
- valvulaEsvaziamento  out  1  drain valve (lowers chamber to downstream level)
- atendendo  out  2  entry side of current transit: 00 none, 01 M, 10 J
- ocupado  out  1  high whenever state is not OCIOSO
- dbEstado  out  4  current state code

Behaviour:
- Reset (async):
  - State OCIOSO; all outputs 0.
  - Pending flags pendM and pendJ cleared.
  - nivelAlto=0 (chamber at downstream level).
  - ultimo=J, so M wins the first tie.
- Request capture:
  - pendX is set on any cycle its pedido input is 1.
  - pendX is cleared in ARBITRA when side X is granted. A pulse arriving in that grant cycle merges into the grant and is not kept as a new request.
- Arbitration (ARBITRA, one cycle):
  - Only one side pending: that side is granted.
  - Both pending: the side opposite to ultimo is granted.
  - Granted side E is the entry side; S is the other (exit) side. ultimo<=E.
- Level rule:
  - M side requires nivelAlto=1; J side requires nivelAlto=0.
  - A NIVELA state is skipped when the level already matches the side it serves.
- Timer:
  - Cleared on every state change.
  - Counts in NIVELA_* and PASSAGEM_* states.
  - The state exits when timer==T-1, so the state lasts exactly T cycles.
- States and transitions (dbEstado code in parentheses):
  - OCIOSO (0): goes to ARBITRA when pendM or pendJ is set.
  - ARBITRA (1): goes to NIVELA_ENTRADA, or to ABRE_ENTRADA if the level already matches E.
  - NIVELA_ENTRADA (2): fill valve if E=M, drain valve if E=J, for T_NIVEL cycles. On exit, nivelAlto<=(E==M).
  - ABRE_ENTRADA (3): abrir_E=1 only while the S gate's fechada=1. Goes to PASSAGEM_ENTRADA on aberta_E.
  - PASSAGEM_ENTRADA (4): abrir_E=1 held for T_PASSAGEM cycles.
  - FECHA_ENTRADA (5): abrir_E=0. Goes to NIVELA_SAIDA on fechada_E (or ABRE_SAIDA if the level already matches S).
  - NIVELA_SAIDA (6): valve for side S, T_NIVEL cycles. On exit, nivelAlto<=(S==M).
  - ABRE_SAIDA (7): mirror of ABRE_ENTRADA for side S; abrir_S=1 only while fechada_E=1.
  - PASSAGEM_SAIDA (8): mirror of PASSAGEM_ENTRADA for side S.
  - FECHA_SAIDA (9): goes to OCIOSO on fechada_S.
  - EMERGENCIA (A): see below.
  - Unused codes: go to OCIOSO; dbEstado=F.
- Outputs are Moore, decoded from the state register and E.
  - atendendo is nonzero only in states 2 to 9.
  - The two valves are never both 1; valves are 0 whenever any abrir is 1.
- Emergency:
  - emergencia=1 in any state sends the next state to EMERGENCIA, with priority over all other transitions.
  - In EMERGENCIA: all abrir and valve outputs are 0.
  - Leaves to OCIOSO only when emergencia=0 and fechadaM=fechadaJ=1.
  - An interrupted equalization leaves nivelAlto unchanged; the next equalization reruns the full T_NIVEL.
  - Pending flags are kept and still captured while in EMERGENCIA.
  - The interrupted transit is abandoned, not resumed.
- Interlock invariant: abrirM&abrirJ==0 in every cycle.

Test Plan:
1. Single M transit. Setup: T_NIVEL=4, T_PASSAGEM=3, after reset, pulse pedidoMontante, gate model answers in 2 cycles. Required:
   - valvulaEnchimento=1 for exactly 4 cycles, then abrirM=1 until abertaM plus 3 cycles.
   - Then valvulaEsvaziamento=1 for 4 cycles, then abrirJ sequence.
   - Ends in OCIOSO with nivelAlto=0, ocupado=0; dbEstado walks 0,1,2,3,4,5,6,7,8,9,0.
2. Tie. pedidoMontante and pedidoJusante pulsed in the same cycle after reset. Required:
   - First transit atendendo=01.
   - Second transit atendendo=10, with its entry NIVELA skipped (state 1 goes directly to 3).
3. Interlock. During ABRE_SAIDA toward J, hold fechadaM=0 for 5 cycles. Required:
   - abrirJ stays 0 for those 5 cycles, asserts the cycle after fechadaM=1.
   - abrirM&abrirJ never 1.
4. Emergency. Assert emergencia in PASSAGEM_ENTRADA. Required:
   - Next cycle dbEstado=A and all abrir and valve outputs 0.
   - Deassert emergencia with fechadaJ=0: state stays A until fechadaJ=1, then goes to OCIOSO.
   - A request pulsed during the emergency is served afterward.
5. Async reset. Assert reset mid NIVELA_ENTRADA, between clock edges. Required:
   - Valve and all other outputs go to 0 immediately, not at the next edge.
   - pendM, pendJ and nivelAlto reset.
6. Queueing. pedidoJusante pulse while an M transit is in state 4. Required:
   - It is captured; after FECHA_SAIDA the block returns to OCIOSO, then ARBITRA grants J on the next cycle.
